// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe -- two-stage pipelined ALU with valid/ready handshaking.
//
// Stage S1 captures an accepted operation (operands + opcode). The ALU
// evaluates combinationally from S1. Stage S2 holds the registered result
// and flags presented to the consumer. The pipeline runs at one operation
// per cycle and stalls cleanly under output backpressure.
//
// Parameters
//   WIDTH     operand/result width (4..32)
//   SHW       shift-amount field width, derived from WIDTH (do not override)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   operation presented
//   in_ready   out  operation accepted when in_valid & in_ready at clk edge
//   a, b       in   operands [WIDTH-1:0]
//   opcode     in   000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT a,
//                   110 SHL a by b[SHW-1:0], 111 SHR (logical) a by b[SHW-1:0]
//   out_valid  out  result presented
//   out_ready  in   result consumed when out_valid & out_ready at clk edge
//   result     out  registered result [WIDTH-1:0]
//   flags      out  registered {carry, zero, negative, overflow}
//
// Build option
//   ALU_PIPE_SAT_EN  when defined, ADD clamps to all-ones on carry-out and
//                    SUB clamps to zero on borrow; carry/overflow still
//                    report the unclamped condition.
// ---------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    // Stage S1: accepted operation
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    op_e              r_s1_op;

    // Stage S2: result presented downstream
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;

    // Handshake
    logic             w_advance;
    logic             w_in_ready;

    // ALU datapath
    logic [SHW-1:0]   w_sh;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_carry;
    logic             w_ovf;
    logic             w_zero;
    logic             w_neg;
    logic [3:0]       w_alu_flags;

    // S2 can take a new value when it is empty or its content leaves this
    // cycle; S1 can take a new op when it is empty or it moves into S2.
    assign w_advance  = !r_s2_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_advance;

    // Extra MSB on add/sub captures carry/borrow. For shifts, the extra bit
    // sits on the side bits leave from, so it ends up holding the last bit
    // shifted out (and 0 when the amount is 0).
    assign w_sh   = r_s1_b[SHW-1:0];
    assign w_sum  = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    assign w_diff = {1'b0, r_s1_a} - {1'b0, r_s1_b};
    assign w_shl  = {1'b0, r_s1_a} << w_sh;
    assign w_shr  = {r_s1_a, 1'b0} >> w_sh;

    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case statement can infer a latch.
        w_alu_res = '0;
        w_carry   = 1'b0;
        w_ovf     = 1'b0;
        unique case (r_s1_op)
            OP_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_carry   = w_sum[WIDTH];
                // Same-sign operands producing an opposite-sign sum
                w_ovf     = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
`ifdef ALU_PIPE_SAT_EN
                if (w_sum[WIDTH]) w_alu_res = '1;
`endif
            end
            OP_SUB: begin
                w_alu_res = w_diff[WIDTH-1:0];
                w_carry   = w_diff[WIDTH];   // borrow: a < b unsigned
                // Opposite-sign operands producing a difference whose sign
                // differs from the minuend
                w_ovf     = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                            (w_diff[WIDTH-1] != r_s1_a[WIDTH-1]);
`ifdef ALU_PIPE_SAT_EN
                if (w_diff[WIDTH]) w_alu_res = '0;
`endif
            end
            OP_AND: w_alu_res = r_s1_a & r_s1_b;
            OP_OR:  w_alu_res = r_s1_a | r_s1_b;
            OP_XOR: w_alu_res = r_s1_a ^ r_s1_b;
            OP_NOT: w_alu_res = ~r_s1_a;
            OP_SHL: begin
                w_alu_res = w_shl[WIDTH-1:0];
                w_carry   = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_alu_res = w_shr[WIDTH:1];
                w_carry   = w_shr[0];
            end
            default: begin
                w_alu_res = '0;
                w_carry   = 1'b0;
                w_ovf     = 1'b0;
            end
        endcase
    end

    // Zero and negative follow the final (possibly clamped) result
    assign w_zero      = (w_alu_res == '0);
    assign w_neg       = w_alu_res[WIDTH-1];
    assign w_alu_flags = {w_carry, w_zero, w_neg, w_ovf};

    // Control state and the visible outputs are reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_flags    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling
            // pre-edge values, so the simultaneous S1 refill and S1->S2
            // move below neither drop nor duplicate an op.
            if (w_in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_advance) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_result <= w_alu_res;
                    r_flags  <= w_alu_flags;
                end
            end
        end
    end

    // NOTE: S1 operand/opcode registers carry no reset; they are only ever
    // observed through r_s1_valid, which is reset above.
    always_ff @(posedge clk) begin
        if (w_in_ready && in_valid) begin
            r_s1_a  <= a;
            r_s1_b  <= b;
            r_s1_op <= op_e'(opcode);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe -- self-checking bench for alu_pipe.
// Main instance WIDTH=8 driven through a scoreboard (expected results are
// queued on accept and compared on consume). Two small instances (WIDTH=16,
// WIDTH=4) cover the width-boundary vectors. Honors ALU_PIPE_SAT_EN.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int W = 8;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   fl;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   fl;
    } exp_t;

    // ---------------- main DUT (WIDTH=8) ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    // ---------------- WIDTH=16 instance ----------------
    logic        u16_in_valid;
    logic        u16_in_ready;
    logic [15:0] u16_a;
    logic [15:0] u16_b;
    logic [2:0]  u16_op;
    logic        u16_out_valid;
    logic        u16_out_ready;
    logic [15:0] u16_result;
    logic [3:0]  u16_flags;

    alu_pipe #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (u16_in_valid),
        .in_ready  (u16_in_ready),
        .a         (u16_a),
        .b         (u16_b),
        .opcode    (u16_op),
        .out_valid (u16_out_valid),
        .out_ready (u16_out_ready),
        .result    (u16_result),
        .flags     (u16_flags)
    );

    // ---------------- WIDTH=4 instance ----------------
    logic       u4_in_valid;
    logic       u4_in_ready;
    logic [3:0] u4_a;
    logic [3:0] u4_b;
    logic [2:0] u4_op;
    logic       u4_out_valid;
    logic       u4_out_ready;
    logic [3:0] u4_result;
    logic [3:0] u4_flags;

    alu_pipe #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (u4_in_valid),
        .in_ready  (u4_in_ready),
        .a         (u4_a),
        .b         (u4_b),
        .opcode    (u4_op),
        .out_valid (u4_out_valid),
        .out_ready (u4_out_ready),
        .result    (u4_result),
        .flags     (u4_flags)
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    // Expected outcome of the operation currently being driven
    logic [W-1:0] drv_res;
    logic [3:0]   drv_fl;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, req, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event did not occur within its cycle budget (t=%0t)",
                 name, $time);
    endtask

    // Reference model, written from the opcode definitions with plain
    // integer arithmetic for an arbitrary width w.
    function automatic void model(input int w, input logic [31:0] ia,
                                  input logic [31:0] ib, input logic [2:0] op,
                                  output logic [31:0] res,
                                  output logic [3:0] fl);
        longint mask, ua, ub, sa, sb, s, r, maxs, mins;
        int     sh;
        logic   c, v;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(ia) & mask;
        ub   = longint'(ib) & mask;
        maxs = (longint'(1) << (w - 1)) - 1;
        mins = -(longint'(1) << (w - 1));
        sa   = (ua > maxs) ? ua - (mask + 1) : ua;
        sb   = (ub > maxs) ? ub - (mask + 1) : ub;
        sh   = int'(ub % (longint'(1) << $clog2(w)));
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (op)
            3'd0: begin
                r = ua + ub;
                c = (r > mask);
                s = sa + sb;
                v = (s > maxs) || (s < mins);
                r = r & mask;
`ifdef ALU_PIPE_SAT_EN
                if (c) r = mask;
`endif
            end
            3'd1: begin
                c = (ua < ub);
                r = (ua - ub) & mask;
                s = sa - sb;
                v = (s > maxs) || (s < mins);
`ifdef ALU_PIPE_SAT_EN
                if (c) r = 0;
`endif
            end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: r = (~ua) & mask;
            3'd6: begin
                r = (ua << sh) & mask;
                c = (sh != 0 && sh <= w) ? (((ua >> (w - sh)) & 1) != 0) : 1'b0;
            end
            default: begin
                r = ua >> sh;
                c = (sh != 0) ? (((ua >> (sh - 1)) & 1) != 0) : 1'b0;
            end
        endcase
        res = r[31:0];
        fl  = {c, (r == 0), (((r >> (w - 1)) & 1) != 0), v};
    endfunction

    // Scoreboard monitor: sample away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_result", 32'(result), 32'(e.res));
                    check("sb_flags", 32'(flags), 32'(e.fl));
                end
            end
            if (in_valid && in_ready) begin
                e.res = drv_res;
                e.fl  = drv_fl;
                sb_q.push_back(e);
            end
        end
    end

    // Present one op and hold it until accepted. Returns #1 after the
    // accepting edge with in_valid low and the data inputs scrambled.
    // rand_bp re-randomises out_ready every stalled cycle.
    task automatic send(input logic [2:0] op, input logic [W-1:0] ta,
                        input logic [W-1:0] tb_v, input logic [W-1:0] er,
                        input logic [3:0] ef, input bit rand_bp);
        int  k;
        bit  ok;
        opcode   = op;
        a        = ta;
        b        = tb_v;
        drv_res  = er;
        drv_fl   = ef;
        in_valid = 1'b1;
        ok = 1'b0;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        end
        if (!ok) fail_timeout("send_accept");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        opcode   = 3'($urandom);
    endtask

    task automatic send_model(input logic [2:0] op, input logic [W-1:0] ta,
                              input logic [W-1:0] tb_v, input bit rand_bp);
        logic [31:0] r;
        logic [3:0]  f;
        model(W, 32'(ta), 32'(tb_v), op, r, f);
        send(op, ta, tb_v, r[W-1:0], f, rand_bp);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (sb_q.size() != 0) fail_timeout("drain");
    endtask

    task automatic run16(input logic [2:0] op, input logic [15:0] ta,
                         input logic [15:0] tb_v, input logic [15:0] er,
                         input logic [3:0] ef);
        int k;
        check("w16_in_ready", 32'(u16_in_ready), 32'd1);
        u16_op = op;
        u16_a = ta;
        u16_b = tb_v;
        u16_in_valid = 1'b1;
        @(posedge clk);
        #1;
        u16_in_valid = 1'b0;
        k = 0;
        while (!u16_out_valid && k < 5) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!u16_out_valid) begin
            fail_timeout("w16_out_valid");
        end else begin
            check("w16_result", 32'(u16_result), 32'(er));
            check("w16_flags", 32'(u16_flags), 32'(ef));
        end
    endtask

    task automatic run4(input logic [2:0] op, input logic [3:0] ta,
                        input logic [3:0] tb_v, input logic [3:0] er,
                        input logic [3:0] ef);
        int k;
        check("w4_in_ready", 32'(u4_in_ready), 32'd1);
        u4_op = op;
        u4_a = ta;
        u4_b = tb_v;
        u4_in_valid = 1'b1;
        @(posedge clk);
        #1;
        u4_in_valid = 1'b0;
        k = 0;
        while (!u4_out_valid && k < 5) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!u4_out_valid) begin
            fail_timeout("w4_out_valid");
        end else begin
            check("w4_result", 32'(u4_result), 32'(er));
            check("w4_flags", 32'(u4_flags), 32'(ef));
        end
    endtask

    // ---------------- vector table (WIDTH=8) ----------------
    vec_t vecs[15];

    initial begin
        // flags = {C, Z, N, V}
`ifdef ALU_PIPE_SAT_EN
        vecs[0]  = '{3'd0, 8'hF0, 8'h20, 8'hFF, 4'b1010};
`else
        vecs[0]  = '{3'd0, 8'hF0, 8'h20, 8'h10, 4'b1000};
`endif
        vecs[1]  = '{3'd1, 8'h80, 8'h01, 8'h7F, 4'b0001};
        vecs[2]  = '{3'd1, 8'h05, 8'h05, 8'h00, 4'b0100};
        vecs[3]  = '{3'd6, 8'h81, 8'h03, 8'h08, 4'b0000};
        vecs[4]  = '{3'd7, 8'h81, 8'h01, 8'h40, 4'b1000};
        vecs[5]  = '{3'd6, 8'h81, 8'h00, 8'h81, 4'b0010};
        vecs[6]  = '{3'd2, 8'hCC, 8'hAA, 8'h88, 4'b0010};
        vecs[7]  = '{3'd3, 8'h0C, 8'h30, 8'h3C, 4'b0000};
        vecs[8]  = '{3'd4, 8'hFF, 8'hFF, 8'h00, 4'b0100};
        vecs[9]  = '{3'd5, 8'h0F, 8'h00, 8'hF0, 4'b0010};
        vecs[10] = '{3'd0, 8'h7F, 8'h01, 8'h80, 4'b0011};
`ifdef ALU_PIPE_SAT_EN
        vecs[11] = '{3'd1, 8'h00, 8'h01, 8'h00, 4'b1100};
        vecs[12] = '{3'd0, 8'hFF, 8'h01, 8'hFF, 4'b1010};
`else
        vecs[11] = '{3'd1, 8'h00, 8'h01, 8'hFF, 4'b1010};
        vecs[12] = '{3'd0, 8'hFF, 8'h01, 8'h00, 4'b1100};
`endif
        vecs[13] = '{3'd7, 8'h80, 8'h07, 8'h01, 4'b0000};
        // Only b[2:0]=7 is used as shift amount
        vecs[14] = '{3'd6, 8'h03, 8'h0F, 8'h80, 4'b1010};
    end

    // ---------------- main sequence ----------------
    initial begin
        int           k;
        bit           seen_block;
        logic [W-1:0] held_res;
        logic [3:0]   held_fl;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        opcode = '0;
        drv_res = '0;
        drv_fl = '0;
        u16_in_valid = 1'b0;
        u16_a = '0;
        u16_b = '0;
        u16_op = '0;
        u16_out_ready = 1'b1;
        u4_in_valid = 1'b0;
        u4_a = '0;
        u4_b = '0;
        u4_op = '0;
        u4_out_ready = 1'b1;

        // Reset state, in_ready high even with out_ready low
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // First accept on the first edge after release; no combinational
        // bypass, result within two edges of acceptance
        out_ready = 1'b1;
        send(3'd0, 8'h12, 8'h34, 8'h46, 4'b0000, 1'b0);
        check("lat_not_early", 32'(out_valid), 32'd0);
        k = 0;
        while (!out_valid && k < 2) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("lat_arrived", 32'(out_valid), 32'd1);
        drain();

        // Table vectors, back to back
        for (int i = 0; i < 15; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl, 1'b0);
        end
        drain();

        // Four back-to-back ops with a 3-cycle output stall mid-stream
        out_ready = 1'b1;
        fork
            begin
                send_model(3'd0, 8'h11, 8'h22, 1'b0);
                send_model(3'd1, 8'h40, 8'h41, 1'b0);
                send_model(3'd4, 8'h5A, 8'hA5, 1'b0);
                send_model(3'd6, 8'h0F, 8'h02, 1'b0);
            end
            begin
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!out_valid && k < 20);
                if (!out_valid) fail_timeout("stall_first_out");
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                held_res = result;
                held_fl = flags;
                seen_block = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_out_valid", 32'(out_valid), 32'd1);
                    check("stall_result_hold", 32'(result), 32'(held_res));
                    check("stall_flags_hold", 32'(flags), 32'(held_fl));
                    if (!in_ready) seen_block = 1'b1;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                check("stall_in_ready_dropped", 32'(seen_block), 32'd1);
            end
        join
        drain();

        // Random ops under random backpressure; idle gaps test that data
        // inputs are ignored while in_valid is low
        for (int i = 0; i < 40; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            send_model(3'($urandom), W'($urandom), W'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        out_ready = 1'b1;
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        send_model(3'd3, 8'h01, 8'h02, 1'b0);
        send_model(3'd2, 8'hF0, 8'h3C, 1'b0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_flags", 32'(flags), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("no_stale_out", 32'(out_valid), 32'd0);
        end

        // Width boundaries
`ifdef ALU_PIPE_SAT_EN
        run16(3'd0, 16'hFFFF, 16'h0001, 16'hFFFF, 4'b1010);
`else
        run16(3'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100);
`endif
        run16(3'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001);
        run4(3'd5, 4'hA, 4'h0, 4'h5, 4'b0000);
        run4(3'd0, 4'h7, 4'h1, 4'h8, 4'b0011);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width (legal range 4..32).
REQ-002 SHALL have parameter: SHW, default $clog2(WIDTH), shift-amount field width, derived and not overridden.
REQ-003 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: in_valid  input  1  operation presented.
REQ-006 SHALL have ports: in_ready  output  1  operation accepted when in_valid & in_ready at clk edge.
REQ-007 SHALL have ports: a, b  input  WIDTH  operands.
REQ-008 SHALL have ports: opcode  input  3  operation select.
REQ-009 SHALL have ports: out_valid  output  1  result presented.
REQ-010 SHALL have ports: out_ready  input  1  result consumed when out_valid & out_ready at clk edge.
REQ-011 SHALL have ports: result  output  WIDTH  registered result.
REQ-012 SHALL have ports: flags  output  4  registered {carry, zero, negative, overflow}, bit 3 = carry.

Function
REQ-013 Opcode map SHALL be: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 NOT a, 110 SHL a by b[SHW-1:0], 111 SHR logical a by b[SHW-1:0].
REQ-014 ADD carry SHALL be the bit-WIDTH carry-out; result wraps modulo 2^WIDTH.
REQ-015 SUB carry SHALL be borrow (1 iff a < b unsigned); result wraps modulo 2^WIDTH.
REQ-016 Overflow SHALL be signed two's-complement overflow for ADD/SUB, 0 for all other opcodes.
REQ-017 SHL/SHR carry SHALL be the last bit shifted out; shift amount 0 gives carry 0 and result = a.
REQ-018 Logical/NOT carry SHALL be 0.
REQ-019 zero SHALL be 1 iff result == 0; negative SHALL equal result[WIDTH-1]; both computed on the final (post-saturation) result.
REQ-020 Pipeline SHALL be two register stages: S1 captures operands/opcode, S2 holds result/flags.
REQ-021 Unstalled latency SHALL be 2 cycles from accept edge to out_valid high; throughput 1 op/cycle.
REQ-022 S2 SHALL load when S2 empty or out_ready=1 (advance); S1 SHALL move to S2 only on advance.
REQ-023 in_ready SHALL be 1 iff S1 empty or advance; combinational from out_ready and stage valids only.
REQ-024 While out_valid=1 and out_ready=0, result and flags SHALL hold stable.
REQ-025 Simultaneous accept and S1->S2 transfer in one cycle SHALL neither drop nor duplicate an op.
REQ-026 Results SHALL emerge in acceptance order.
REQ-027 Data inputs SHALL be ignored when in_valid=0; no op is fabricated.

Reset
REQ-028 rst=1 SHALL asynchronously clear both stage valids; out_valid=0, result=0, flags=4'b0000.
REQ-029 in_ready SHALL be 1 while out_ready... during and immediately after reset (both stages empty).
REQ-030 Reset mid-operation SHALL discard all in-flight ops; none appear after release.
REQ-031 First accept SHALL be possible on the first rising edge with rst low.

Configuration
REQ-032 Macro ALU_PIPE_SAT_EN SHALL, when defined, make ADD clamp to all-ones on carry and SUB clamp to 0 on borrow; carry/overflow flags still report the unclamped condition.
REQ-033 Without ALU_PIPE_SAT_EN, ADD/SUB SHALL wrap per REQ-014/015; no other behaviour differs.

Verification
REQ-034 WIDTH=8, ADD a=0xF0 b=0x20, out_ready=1 -> 2 cycles later result=0x10 flags C=1 Z=0 N=0 V=0 (SAT_EN: result=0xFF, C=1).
REQ-035 WIDTH=8, SUB a=0x80 b=0x01 -> result=0x7F, C=0, V=1, N=0; SUB a=0x05 b=0x05 -> result=0x00, Z=1, C=0.
REQ-036 WIDTH=8, SHL a=0x81 b=3 -> result=0x08, C=0; SHR a=0x81 b=1 -> result=0x40, C=1; SHL b=0 -> result=0x81, C=0.
REQ-037 Back-to-back 4 ops, out_ready held 0 for 3 cycles mid-stream -> in_ready drops after S1 and S2 fill, result stable, all 4 results delivered in order, none lost.
REQ-038 rst asserted while S1 and S2 valid -> out_valid=0 immediately, result=0, flags=0; after release no stale result appears.
REQ-039 WIDTH=16 and WIDTH=4 builds: ADD 0xFFFF+1 -> 0x0000 C=1 Z=1; 4-bit NOT a=0xA -> 0x5, C=0.
